// File: rtl/poly_mult_result_reader.sv
// poly_mult_result_reader
// -----------------------
// Read-back side of the poly_mult host interface. The host asks for a
// 128-bit block by index. This block reads four consecutive result words
// from poly_mult's result RAM, packs them, and returns the block on data_o
// with a one-cycle done_o pulse.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start_i         new multiplication launched; drops the held result
//   valid_i         poly_mult result RAM is complete
//   rd_i, key_i     host read request and block index, sampled together
//   addr_result_o   result RAM word address
//   rd_dout_o       result RAM read enable
//   dout_i          result word, valid one cycle after rd_dout_o
//   data_o          packed block; word k on bits [32k+31:32k]
//   done_o, err_o   completion pulse; err_o marks a rejected request
//   busy_o          request in progress
//   ready_o         a result is available for read-back
module poly_mult_result_reader #(
    parameter int RAMWIDTH        = 32,
    parameter int RESULT_WORDS    = 553,
    parameter int ADDR_WIDTH      = 11,
    parameter int KEY_WIDTH       = 10,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 139
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  valid_i,
    input  logic                  rd_i,
    input  logic [KEY_WIDTH-1:0]  key_i,
    output logic [ADDR_WIDTH-1:0] addr_result_o,
    output logic                  rd_dout_o,
    input  logic [RAMWIDTH-1:0]   dout_i,
    output logic [127:0]          data_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  ready_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(RESULT_WORDS);
    localparam logic [KEY_WIDTH-1:0]  KEY_LIMIT  = KEY_WIDTH'(NUM_BLOCKS);
    localparam logic [2:0]            LAST_CNT   = 3'(WORDS_PER_BLOCK - 1);
    localparam logic [2:0]            FINAL_CNT  = 3'(WORDS_PER_BLOCK);

    logic [2:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_q, rd_d;
    logic                  rdv_q, rdv_d;
    logic [127:0]          blk_q, blk_d;
    logic [127:0]          data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [1:0]            lane;

    // Word 0 is issued on the accepting edge, so the counter runs one
    // word behind the address stream; captures trail issues by two edges.
    assign next_addr = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
    assign lane      = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        rdv_d   = rd_q;       // read enable delayed to line up with dout_i
        blk_d   = blk_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (start_i) begin
            state_d = S_IDLE;
            rdv_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_i) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                    if (valid_i) begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (rd_i) begin
                        if (key_i < KEY_LIMIT) begin
                            base_d  = ADDR_WIDTH'({key_i, 2'b00});
                            addr_d  = base_d;
                            rd_d    = (base_d < WORD_LIMIT);
                            cnt_d   = 3'd0;
                            blk_d   = '0;
                            state_d = S_FETCH;
                        end else begin
                            data_d = 128'h1;
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    end
                end
                S_FETCH, S_DRAIN: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < LAST_CNT) begin
                        addr_d = next_addr;
                        rd_d   = (next_addr < WORD_LIMIT);
                    end
                    // Out-of-range lanes were never read; force them to zero.
                    if (cnt_q != 3'd0) begin
                        blk_d[int'(lane)*RAMWIDTH +: RAMWIDTH] = rdv_q ? dout_i : '0;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DRAIN;
                    end else if (cnt_q == FINAL_CNT) begin
                        state_d = S_RESP;
                    end
                end
                S_RESP: begin
                    data_d  = blk_q;
                    done_d  = 1'b1;
                    state_d = S_READY;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            base_q  <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            rdv_q   <= 1'b0;
            blk_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            rdv_q   <= rdv_d;
            blk_q   <= blk_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign addr_result_o = addr_q;
    assign rd_dout_o     = rd_q;
    assign data_o        = data_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign busy_o        = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_RESP);
    assign ready_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_poly_mult_result_reader.sv
// Testbench for poly_mult_result_reader: directed requests against a
// behavioural result-RAM and transaction model, with literal expectations.
module tb_poly_mult_result_reader;

    localparam int NWORDS = 553;
    localparam int NBLK   = 139;

    logic         clk = 1'b0;
    logic         rst, start_i, valid_i, rd_i;
    logic [9:0]   key_i;
    logic [10:0]  addr_result_o;
    logic         rd_dout_o;
    logic [31:0]  dout_i;
    logic [127:0] data_o;
    logic         done_o, err_o, busy_o, ready_o;

    poly_mult_result_reader dut (
        .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
        .rd_i(rd_i), .key_i(key_i), .addr_result_o(addr_result_o),
        .rd_dout_o(rd_dout_o), .dout_i(dout_i), .data_o(data_o),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_base = 32'hA000_0000;

    function automatic logic [31:0] word(input int j);
        return mem_base + 32'(j);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Result RAM: one-cycle read latency, garbage when not read.
    always @(posedge clk)
        dout_i <= rd_dout_o ? word(int'(addr_result_o)) : 32'hDEAD_BEEF;

    // Transaction model: what each output must be after each edge.
    int           cyc = 0;
    bit           m_ready, m_active, m_done, m_err, m_rd;
    int           m_key, m_t0;
    logic [10:0]  m_addr;
    logic [127:0] m_data;

    task automatic issue(input int k);
        int w;
        w      = 4 * m_key + k;
        m_addr = 11'(w);
        m_rd   = (w < NWORDS);
    endtask

    always @(posedge clk) begin
        int k;
        cyc++;
        m_done = 0; m_err = 0; m_rd = 0;
        if (rst) begin
            m_ready = 0; m_active = 0; m_data = '0; m_addr = '0;
        end else if (start_i) begin
            m_ready = 0; m_active = 0;
        end else if (!m_ready) begin
            if (rd_i) begin m_done = 1; m_err = 1; end
            if (valid_i) m_ready = 1;
        end else if (m_active) begin
            k = cyc - m_t0;
            if (k <= 3) issue(k);
            if (k == 6) begin
                m_done = 1; m_active = 0;
                for (int l = 0; l < 4; l++) begin
                    int w;
                    w = 4 * m_key + l;
                    m_data[32*l +: 32] = (w < NWORDS) ? word(w) : 32'h0;
                end
            end
        end else if (rd_i) begin
            if (int'(key_i) < NBLK) begin
                m_active = 1; m_t0 = cyc; m_key = int'(key_i); issue(0);
            end else begin
                m_done = 1; m_err = 1; m_data = 128'h1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("done_o", done_o, m_done);
            chk("err_o", err_o, m_err);
            chk("ready_o", ready_o, m_ready);
            chk("busy_o", busy_o, m_active);
            chk("rd_dout_o", rd_dout_o, m_rd);
            if (m_rd) chk("addr_result_o", addr_result_o, m_addr);
            chk("data_o", data_o, m_data);
        end
    end

    int issued_q[$];

    // Issue one request, collect issued addresses, wait (bounded) for done.
    task automatic req(input int key, output logic [127:0] d, output logic e, output int lat);
        issued_q.delete();
        rd_i  = 1'b1;
        key_i = 10'(key);
        lat   = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            rd_i = 1'b0;
            if (rd_dout_o) issued_q.push_back(int'(addr_result_o));
            if (done_o) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) chk("req_timeout", 0, 1);
        d = data_o;
        e = err_o;
    endtask

    logic [127:0] d;
    logic         e;
    int           lat, ndone;

    initial begin
        rst = 1'b1; start_i = 1'b0; valid_i = 1'b0; rd_i = 1'b0; key_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_data", data_o, 128'h0);
        chk("rst_addr", addr_result_o, 0);
        chk("rst_flags", {rd_dout_o, done_o, err_o, busy_o, ready_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Read before any result exists.
        req(0, d, e, lat);
        chk("idle_lat", lat, 0);
        chk("idle_err", e, 1);
        chk("idle_data", d, 128'h0);
        chk("idle_ready", ready_o, 0);

        valid_i = 1'b1; @(negedge clk); valid_i = 1'b0;
        chk("valid_ready", ready_o, 1);

        req(0, d, e, lat);
        chk("k0_lat", lat, 6);
        chk("k0_nissue", issued_q.size(), 4);
        for (int i = 0; i < 4 && i < issued_q.size(); i++) chk("k0_addr", issued_q[i], i);
        chk("k0_data", d, 128'hA0000003_A0000002_A0000001_A0000000);
        chk("k0_err", e, 0);
        @(negedge clk);

        req(138, d, e, lat);
        chk("k138_nissue", issued_q.size(), 1);
        if (issued_q.size() > 0) chk("k138_addr", issued_q[0], 552);
        chk("k138_data", d, 128'h00000000_00000000_00000000_A0000228);
        chk("k138_err", e, 0);
        @(negedge clk);

        req(139, d, e, lat);
        chk("k139_lat", lat, 0);
        chk("k139_nissue", issued_q.size(), 0);
        chk("k139_data", d, 128'h1);
        chk("k139_err", e, 1);
        req(1023, d, e, lat);
        chk("k1023_lat", lat, 0);
        chk("k1023_data", d, 128'h1);
        chk("k1023_err", e, 1);
        @(negedge clk);

        // Second rd_i during a fetch must be ignored.
        rd_i = 1'b1; key_i = 10'd2;
        @(negedge clk); rd_i = 1'b0;
        @(negedge clk); rd_i = 1'b1; key_i = 10'd3;
        @(negedge clk); rd_i = 1'b0;
        ndone = 0;
        for (int n = 0; n < 14; n++) begin
            if (done_o) begin
                ndone++;
                chk("dbl_data", data_o, 128'hA000000B_A000000A_A0000009_A0000008);
            end
            @(negedge clk);
        end
        chk("dbl_ndone", ndone, 1);

        // start_i at E3 aborts the fetch.
        rd_i = 1'b1; key_i = 10'd5;
        @(negedge clk); rd_i = 1'b0;
        @(negedge clk);
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("abort_ready", ready_o, 0);
        chk("abort_busy", busy_o, 0);
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            if (done_o) ndone++;
            @(negedge clk);
        end
        chk("abort_ndone", ndone, 0);
        mem_base = 32'hB000_0000;
        valid_i = 1'b1; @(negedge clk); valid_i = 1'b0;
        req(5, d, e, lat);
        chk("k5_data", d, 128'hB0000017_B0000016_B0000015_B0000014);
        chk("k5_lat", lat, 6);
        @(negedge clk);

        // Reset at E2 of a fetch.
        rd_i = 1'b1; key_i = 10'd7;
        @(negedge clk); rd_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rstmid_data", data_o, 128'h0);
        chk("rstmid_addr", addr_result_o, 0);
        chk("rstmid_flags", {rd_dout_o, done_o, err_o, busy_o, ready_o}, 0);
        ndone = 0;
        for (int n = 0; n < 8; n++) begin
            if (done_o) ndone++;
            @(negedge clk);
        end
        chk("rstmid_ndone", ndone, 0);
        req(1, d, e, lat);
        chk("rstmid_idle_err", e, 1);
        chk("rstmid_idle_lat", lat, 0);
        valid_i = 1'b1; @(negedge clk); valid_i = 1'b0;
        req(1, d, e, lat);
        chk("k1_data", d, 128'hB0000007_B0000006_B0000005_B0000004);
        chk("k1_err", e, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
